// File: rtl/johnson_monitor.sv
// ---------------------------------------------------------------------------
// johnson_monitor
//
// Watches a 3-bit Johnson code from an upstream shift stage, decodes it into
// a phase index 0..5, flags illegal codes and illegal jumps, and runs a small
// lock FSM. While locked, it counts completed Johnson cycles (5->0 advances).
//
// Ports
//   clock        : single clock, rising edge
//   clear_n      : asynchronous active-low reset
//   state_in     : 3-bit Johnson code
//   enable       : qualifies sampling of state_in; 0 holds all state
//   err_clr      : request to leave FAULT (only acted on during a sample)
//   phase        : registered decoded phase 0..5
//   phase_valid  : 1 when the last sample was a legal code
//   illegal_err  : one-cycle pulse, last sample was an illegal code
//   step_err     : one-cycle pulse, last sample was legal but not hold/advance
//   locked       : FSM is in LOCKED
//   fault        : FSM is in FAULT
//   cycle_count  : completed Johnson cycles while locked (wraps)
//   dbg_state    : FSM state (0 UNLOCK, 1 ACQUIRE, 2 LOCKED, 3 FAULT)
//   dbg_good_cnt : consecutive-advance counter used for acquisition
//
// Handshake: none. A "sample" is any rising clock edge with enable=1; every
// output is registered and reflects the most recent sample one edge later.
// ---------------------------------------------------------------------------
module johnson_monitor #(
  parameter int LOCK_STEPS = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [2:0]       state_in,
  input  logic             enable,
  input  logic             err_clr,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             illegal_err,
  output logic             step_err,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       dbg_state,
  output logic [3:0]       dbg_good_cnt
);

  typedef enum logic [1:0] {
    ST_UNLOCK  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [3:0]       LP_LOCK    = LOCK_STEPS[3:0];
  localparam logic [CNT_W-1:0] LP_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_phase;
  logic             r_phase_valid;
  logic             r_illegal_err;
  logic             r_step_err;
  logic [3:0]       r_good_cnt;
  logic [CNT_W-1:0] r_cycle_count;
  // Previous-sample record: r_phase holds the last legal phase, this bit says
  // whether it may be used as the reference for the step check.
  logic             r_prev_valid;

  logic             w_sample;
  logic             w_legal;
  logic [2:0]       w_dec;
  logic [2:0]       w_phase_adv;
  logic             w_hold;
  logic             w_adv;
  logic             w_step;
  logic             w_illegal;
  logic             w_err;
  logic             w_count_adv;
  logic             w_wrap;
  logic [3:0]       w_good_inc;
  logic [3:0]       w_good_next;
  logic             w_clear_prev;
  logic             w_cc_clear;
  logic             w_cc_inc;

  // Johnson decode
  always_comb begin
    w_legal = 1'b1;
    w_dec   = 3'd0;
    case (state_in)
      3'b000:  w_dec = 3'd0;
      3'b001:  w_dec = 3'd1;
      3'b011:  w_dec = 3'd2;
      3'b111:  w_dec = 3'd3;
      3'b110:  w_dec = 3'd4;
      3'b100:  w_dec = 3'd5;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_sample    = enable;
  assign w_phase_adv = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;
  assign w_hold      = (w_dec == r_phase);
  assign w_adv       = (w_dec == w_phase_adv);
  assign w_illegal   = w_sample & ~w_legal;
  // Step check only against a valid reference; a seed sample never errors.
  assign w_step      = w_sample & w_legal & r_prev_valid & ~w_hold & ~w_adv;
  assign w_err       = w_illegal | w_step;
  assign w_count_adv = w_sample & w_legal & r_prev_valid & w_adv;
  assign w_wrap      = w_count_adv & (r_phase == 3'd5);
  assign w_good_inc  = r_good_cnt + 4'd1;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    w_clear_prev = 1'b0;
    w_cc_clear   = 1'b0;
    w_cc_inc     = 1'b0;
    case (r_state)
      ST_UNLOCK: begin
        if (w_sample && w_legal) begin
          w_state_next = ST_ACQUIRE;
          w_good_next  = 4'd0;
          w_cc_clear   = 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (w_err) begin
          w_state_next = ST_UNLOCK;
          w_clear_prev = 1'b1;
        end else if (w_count_adv) begin
          w_good_next = w_good_inc;
          if (w_good_inc == LP_LOCK) w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_err)       w_state_next = ST_FAULT;
        else if (w_wrap) w_cc_inc     = 1'b1;
      end
      ST_FAULT: begin
        // err_clr wins over a coincident error; the error still pulses.
        if (w_sample && err_clr) begin
          w_state_next = ST_UNLOCK;
          w_clear_prev = 1'b1;
        end
      end
      default: w_state_next = ST_UNLOCK;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state       <= ST_UNLOCK;
      r_phase       <= 3'd0;
      r_phase_valid <= 1'b0;
      r_illegal_err <= 1'b0;
      r_step_err    <= 1'b0;
      r_good_cnt    <= 4'd0;
      r_cycle_count <= '0;
      r_prev_valid  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_good_cnt    <= w_good_next;
      r_illegal_err <= w_illegal;
      r_step_err    <= w_step;
      if (w_sample) begin
        r_phase_valid <= w_legal;
        if (w_legal) r_phase <= w_dec;
        r_prev_valid  <= w_legal & ~w_clear_prev;
      end
      if (w_cc_clear)    r_cycle_count <= '0;
      else if (w_cc_inc) r_cycle_count <= r_cycle_count + LP_CNT_ONE;
    end
  end

  assign phase        = r_phase;
  assign phase_valid  = r_phase_valid;
  assign illegal_err  = r_illegal_err;
  assign step_err     = r_step_err;
  assign locked       = (r_state == ST_LOCKED);
  assign fault        = (r_state == ST_FAULT);
  assign cycle_count  = r_cycle_count;
  assign dbg_state    = r_state;
  assign dbg_good_cnt = r_good_cnt;

endmodule

// File: tb/tb_johnson_monitor.sv
// ---------------------------------------------------------------------------
// tb_johnson_monitor
//
// Two instances share the same stimulus: u_dut (CNT_W=8) and u_dut2
// (CNT_W=2, for the cycle_count wrap). Vectors are {inputs, expected
// outputs after the next rising edge}; a few hand-written sequences cover
// asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_johnson_monitor;

  localparam logic [1:0] U = 2'd0, A = 2'd1, L = 2'd2, F = 2'd3;

  typedef struct {
    logic       en;
    logic [2:0] code;
    logic       clr;
    logic [2:0] ph;
    logic       pv;
    logic       ie;
    logic       se;
    logic [1:0] st;
    logic [3:0] good;
    logic [7:0] cc;
  } vec_t;

  // clock / reset
  logic       clock = 1'b0;
  logic       clear_n;
  logic [2:0] state_in;
  logic       enable;
  logic       err_clr;

  logic [2:0] phase, phase2;
  logic       phase_valid, phase_valid2;
  logic       illegal_err, illegal_err2;
  logic       step_err, step_err2;
  logic       locked, locked2;
  logic       fault, fault2;
  logic [7:0] cycle_count;
  logic [1:0] cycle_count2;
  logic [1:0] dbg_state, dbg_state2;
  logic [3:0] dbg_good_cnt, dbg_good_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t       vecs[$];
  logic [2:0] jc[0:5];

  always #5 clock = ~clock;

  johnson_monitor #(.LOCK_STEPS(4), .CNT_W(8)) u_dut (
    .clock(clock), .clear_n(clear_n), .state_in(state_in), .enable(enable),
    .err_clr(err_clr), .phase(phase), .phase_valid(phase_valid),
    .illegal_err(illegal_err), .step_err(step_err), .locked(locked),
    .fault(fault), .cycle_count(cycle_count), .dbg_state(dbg_state),
    .dbg_good_cnt(dbg_good_cnt)
  );

  johnson_monitor #(.LOCK_STEPS(4), .CNT_W(2)) u_dut2 (
    .clock(clock), .clear_n(clear_n), .state_in(state_in), .enable(enable),
    .err_clr(err_clr), .phase(phase2), .phase_valid(phase_valid2),
    .illegal_err(illegal_err2), .step_err(step_err2), .locked(locked2),
    .fault(fault2), .cycle_count(cycle_count2), .dbg_state(dbg_state2),
    .dbg_good_cnt(dbg_good_cnt2)
  );

  function automatic vec_t mk(input logic en, input logic [2:0] code,
                              input logic clr, input logic [2:0] ph,
                              input logic pv, input logic ie, input logic se,
                              input logic [1:0] st, input logic [3:0] good,
                              input logic [7:0] cc);
    vec_t v;
    v.en = en; v.code = code; v.clr = clr; v.ph = ph; v.pv = pv;
    v.ie = ie; v.se = se; v.st = st; v.good = good; v.cc = cc;
    return v;
  endfunction

  task automatic add(input logic en, input logic [2:0] code, input logic clr,
                     input logic [2:0] ph, input logic pv, input logic ie,
                     input logic se, input logic [1:0] st,
                     input logic [3:0] good, input logic [7:0] cc);
    vecs.push_back(mk(en, code, clr, ph, pv, ie, se, st, good, cc));
  endtask

  // scoreboard compare
  task automatic check_field(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t e);
    check_field("phase",        idx, 32'(phase),        32'(e.ph));
    check_field("phase_valid",  idx, 32'(phase_valid),  32'(e.pv));
    check_field("illegal_err",  idx, 32'(illegal_err),  32'(e.ie));
    check_field("step_err",     idx, 32'(step_err),     32'(e.se));
    check_field("locked",       idx, 32'(locked),       32'(e.st == L));
    check_field("fault",        idx, 32'(fault),        32'(e.st == F));
    check_field("state",        idx, 32'(dbg_state),    32'(e.st));
    check_field("good_cnt",     idx, 32'(dbg_good_cnt), 32'(e.good));
    check_field("cycle_count",  idx, 32'(cycle_count),  32'(e.cc));
    check_field("cycle_count2", idx, 32'(cycle_count2), 32'(e.cc[1:0]));
  endtask

  // driver
  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    enable   = v.en;
    state_in = v.code;
    err_clr  = v.clr;
    @(posedge clock);
    #1;
    check_all(idx, v);
  endtask

  initial begin
    jc[0] = 3'b000; jc[1] = 3'b001; jc[2] = 3'b011;
    jc[3] = 3'b111; jc[4] = 3'b110; jc[5] = 3'b100;

    // acquisition: seed + 4 advances -> LOCKED after the 5th sample
    add(1, 3'b000, 0, 0, 1, 0, 0, A, 0, 0);
    add(1, 3'b001, 0, 1, 1, 0, 0, A, 1, 0);
    add(1, 3'b011, 0, 2, 1, 0, 0, A, 2, 0);
    add(1, 3'b111, 0, 3, 1, 0, 0, A, 3, 0);
    add(1, 3'b110, 0, 4, 1, 0, 0, L, 4, 0);
    // five full cycles while locked; each 5->0 counts
    for (int k = 0; k < 5; k++) begin
      add(1, jc[5], 0, 5, 1, 0, 0, L, 4, 8'(k));
      add(1, jc[0], 0, 0, 1, 0, 0, L, 4, 8'(k + 1));
      for (int p = 1; p < 5; p++)
        add(1, jc[p], 0, p[2:0], 1, 0, 0, L, 4, 8'(k + 1));
    end
    // illegal while locked -> FAULT, phase held, count frozen afterwards
    add(1, 3'b010, 0, 4, 0, 1, 0, F, 4, 5);
    add(1, 3'b110, 0, 4, 1, 0, 0, F, 4, 5);
    add(1, 3'b100, 0, 5, 1, 0, 0, F, 4, 5);
    add(1, 3'b000, 0, 0, 1, 0, 0, F, 4, 5);
    // jump 0->3 with err_clr in FAULT: err_clr wins, step_err still pulses
    add(1, 3'b111, 1, 3, 1, 0, 1, U, 4, 5);
    // seed clears cycle_count, then jump 1->3 at good_cnt=2
    add(1, 3'b100, 0, 5, 1, 0, 0, A, 0, 0);
    add(1, 3'b000, 0, 0, 1, 0, 0, A, 1, 0);
    add(1, 3'b001, 0, 1, 1, 0, 0, A, 2, 0);
    add(1, 3'b111, 0, 3, 1, 0, 1, U, 2, 0);
    // 3->2 is only a seed after UNLOCK, no step error
    add(1, 3'b011, 0, 2, 1, 0, 0, A, 0, 0);
    // holds leave good_cnt alone; err_clr ignored outside FAULT
    for (int k = 0; k < 5; k++)
      add(1, 3'b011, (k == 2), 2, 1, 0, 0, A, 0, 0);
    // illegal in ACQUIRE -> UNLOCK, phase held
    add(1, 3'b101, 0, 2, 0, 1, 0, U, 0, 0);
    // relock; 5->0 while acquiring does not count
    add(1, 3'b011, 0, 2, 1, 0, 0, A, 0, 0);
    add(1, 3'b111, 0, 3, 1, 0, 0, A, 1, 0);
    add(1, 3'b110, 0, 4, 1, 0, 0, A, 2, 0);
    add(1, 3'b100, 0, 5, 1, 0, 0, A, 3, 0);
    add(1, 3'b000, 0, 0, 1, 0, 0, L, 4, 0);
    add(1, 3'b001, 1, 1, 1, 0, 0, L, 4, 0);
    // enable=0: illegal codes and err_clr have no effect
    add(0, 3'b010, 1, 1, 1, 0, 0, L, 4, 0);
    add(0, 3'b101, 1, 1, 1, 0, 0, L, 4, 0);
    add(0, 3'b010, 0, 1, 1, 0, 0, L, 4, 0);
    add(0, 3'b101, 0, 1, 1, 0, 0, L, 4, 0);

    // reset state, asserted asynchronously before any clock edge
    clear_n  = 1'b1;
    enable   = 1'b0;
    state_in = 3'b000;
    err_clr  = 1'b0;
    #2 clear_n = 1'b0;
    #1 check_all(-1, mk(0, 0, 0, 0, 0, 0, 0, U, 0, 0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // async reset mid-LOCKED, away from any clock edge
    @(negedge clock);
    enable = 1'b0;
    #1 clear_n = 1'b0;
    #1 check_all(-2, mk(0, 0, 0, 0, 0, 0, 0, U, 0, 0));
    @(negedge clock);
    clear_n = 1'b1;
    // first sample after reset only seeds
    apply(mk(1, 3'b110, 0, 4, 1, 0, 0, A, 0, 0), -3);
    apply(mk(1, 3'b100, 0, 5, 1, 0, 0, A, 1, 0), -4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_monitor.md
JOHNSON_MONITOR -- requirements
Module: johnson_monitor

Interface
REQ-001 Parameter LOCK_STEPS, default 4, SHALL set the number of consecutive legal advances needed to declare lock (range 1..15).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of cycle_count.
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 clear_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 state_in  input  3  SHALL carry the 3-bit Johnson code from the upstream shift stage.
REQ-006 enable  input  1  SHALL qualify sampling of state_in; when 0, the block SHALL hold all state.
REQ-007 err_clr  input  1  SHALL be the request to leave FAULT.
REQ-008 phase  output  3  SHALL carry the decoded phase index 0..5.
REQ-009 phase_valid  output  1  SHALL be 1 when phase holds a decode of a legal code.
REQ-010 illegal_err  output  1  SHALL be a one-cycle pulse for an illegal code.
REQ-011 step_err  output  1  SHALL be a one-cycle pulse for a legal code that is not a hold or a single advance.
REQ-012 locked  output  1  SHALL be 1 while the FSM is in LOCKED.
REQ-013 fault  output  1  SHALL be 1 while the FSM is in FAULT.
REQ-014 cycle_count  output  CNT_W  SHALL count completed Johnson cycles while locked.

Function
REQ-015 Legal codes SHALL be (state_in[2:0]) 000=0, 001=1, 011=2, 111=3, 110=4, 100=5; codes 010 and 101 SHALL be illegal.
REQ-016 A sample is defined as a rising edge with enable=1; all decode outputs SHALL be registered, with 1-cycle latency from sample to output.
REQ-017 On each sample, phase SHALL load the decode of state_in, or hold its previous value if the code is illegal; phase_valid SHALL load legal(state_in).
REQ-018 Hold (new phase = old phase) and advance (new phase = (old+1) mod 6, so 5->0 wraps) SHALL be legal transitions; any other legal-to-legal change SHALL pulse step_err.
REQ-019 No step check SHALL apply when the previous sample was illegal or no sample has been taken since reset/UNLOCK; the first legal sample only seeds the comparison.
REQ-020 illegal_err and step_err SHALL never both be 1 in the same cycle; both SHALL be 0 on cycles without a sample.
REQ-021 FSM states SHALL be UNLOCK, ACQUIRE, LOCKED and FAULT.
REQ-022 UNLOCK->ACQUIRE SHALL occur on a legal sample; good_cnt SHALL be cleared.
REQ-023 In ACQUIRE, each advance SHALL increment good_cnt and holds SHALL leave it unchanged; on reaching LOCK_STEPS the FSM SHALL go to LOCKED, and any error SHALL return it to UNLOCK.
REQ-024 On entry to ACQUIRE, cycle_count SHALL clear to 0.
REQ-025 In LOCKED, each 5->0 advance SHALL increment cycle_count, which SHALL wrap from all-ones to 0.
REQ-026 In LOCKED, any error SHALL move the FSM to FAULT, where cycle_count SHALL freeze.
REQ-027 In FAULT, err_clr=1 SHALL move the FSM to UNLOCK; err_clr SHALL be ignored in all other states.
REQ-028 If err_clr and an error coincide in FAULT, err_clr SHALL win (->UNLOCK) and the error SHALL still pulse.
REQ-029 locked and fault SHALL be decoded from registered state (no combinational path from inputs).

Reset
REQ-030 While clear_n=0, phase=0, phase_valid=0, illegal_err=0, step_err=0, locked=0, fault=0, cycle_count=0, good_cnt=0, FSM=UNLOCK, and the previous-sample record SHALL be invalid, asynchronously.
REQ-031 Reset asserted mid-operation SHALL abort lock/fault immediately; after release, the first sample SHALL be treated as the seed sample.

Verification
REQ-032 Reset, then enable=1 with codes 000,001,011,111,110 -> locked=1 one cycle after the 5th sample (LOCK_STEPS=4), phase=4, no error pulses.
REQ-033 While locked, run 3 full cycles ending on 000 -> cycle_count=3; wrap case with CNT_W=2 and 5 cycles -> cycle_count=1.
REQ-034 While locked, drive 010 -> illegal_err pulse, phase held, phase_valid=0, fault=1, locked=0; err_clr=1 -> FSM in UNLOCK next cycle.
REQ-035 In ACQUIRE at good_cnt=2, jump 001->111 -> step_err pulse, back to UNLOCK, locked stays 0; repeated holds (011 x5) -> good_cnt unchanged, no error.
REQ-036 With enable=0 and state_in toggling through illegal codes -> all outputs frozen; clear_n pulsed low mid-LOCKED -> all outputs 0 asynchronously.
